// File: rtl/graphite_cmd_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : graphite_cmd_pkg
// Purpose  : Register map, STATUS/CTRL bit positions and STATUS packing helper
//            shared by the Graphite command transmitter.
// Revision : 1.0
// ============================================================================
package graphite_cmd_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATS  = 2'd3;

  localparam int STATUS_EMPTY_BIT  = 16;
  localparam int STATUS_FULL_BIT   = 17;
  localparam int STATUS_OVF_BIT    = 18;
  localparam int STATUS_TVALID_BIT = 19;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  function automatic logic [31:0] pack_status(
    input logic [15:0] level,
    input logic        empty,
    input logic        full,
    input logic        ovf,
    input logic        tvalid
  );
    logic [31:0] s;
    s                    = '0;
    s[15:0]              = level;
    s[STATUS_EMPTY_BIT]  = empty;
    s[STATUS_FULL_BIT]   = full;
    s[STATUS_OVF_BIT]    = ovf;
    s[STATUS_TVALID_BIT] = tvalid;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/graphite_cmd_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : graphite_bus_if / graphite_axis_if
// Purpose  : CPU register-bus and command AXI-stream bundles.
// Revision : 1.0
// ============================================================================
interface graphite_bus_if;
  logic        sel_i;
  logic        wr_i;
  logic [1:0]  addr_i;
  logic [31:0] data_in_i;
  logic [31:0] data_out_o;
  logic        ack_o;

  modport master (output sel_i, wr_i, addr_i, data_in_i, input data_out_o, ack_o);
  modport slave  (input sel_i, wr_i, addr_i, data_in_i, output data_out_o, ack_o);
endinterface

interface graphite_axis_if;
  logic        cmd_axis_tvalid_o;
  logic        cmd_axis_tready_i;
  logic [31:0] cmd_axis_tdata_o;

  modport master (output cmd_axis_tvalid_o, cmd_axis_tdata_o, input cmd_axis_tready_i);
  modport slave  (input cmd_axis_tvalid_o, cmd_axis_tdata_o, output cmd_axis_tready_i);
endinterface
`default_nettype wire

// File: rtl/graphite_cmd_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with push/pop/flush and level/full/empty.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic               w_push_ok;
  logic               w_pop_ok;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign w_push_ok = push & ~full & ~flush;
  assign w_pop_ok  = pop & ~empty;

  assign full  = (r_level == LEVEL_W'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;
  assign rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LEVEL_W'(1);
        2'b01:   r_level <= r_level - LEVEL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/graphite_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : graphite_cmd_tx
// Purpose  : CPU command transmitter: register bus -> FIFO -> AXI-stream.
//            GRAPHITE_CMD_TX_STATS_EN adds an accepted-word counter at reg 3.
// Revision : 1.0
// ============================================================================
module graphite_cmd_tx
  import graphite_cmd_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n_i,
  graphite_bus_if.slave    bus,
  graphite_axis_if.master  cmd_axis,
  output logic             irq_o
);

  logic               r_ack;
  logic [31:0]        r_data_out;
  logic               r_tvalid;
  logic [31:0]        r_tdata;
  logic               r_ovf;

  logic               w_accept;
  logic               w_wr_data;
  logic               w_wr_ctrl;
  logic               w_wr_stats;
  logic               w_flush;
  logic               w_clr_ovf;
  logic               w_load;
  logic               w_xfer;
  logic [31:0]        w_head;
  logic [LEVEL_W-1:0] w_level;
  logic               w_full;
  logic               w_empty;
  logic [31:0]        w_stats;
  logic [31:0]        w_rdata;

  assign w_accept   = bus.sel_i & ~r_ack;
  assign w_wr_data  = w_accept & bus.wr_i & (bus.addr_i == REG_DATA);
  assign w_wr_ctrl  = w_accept & bus.wr_i & (bus.addr_i == REG_CTRL);
  assign w_wr_stats = w_accept & bus.wr_i & (bus.addr_i == REG_STATS);
  assign w_flush    = w_wr_ctrl & bus.data_in_i[CTRL_FLUSH_BIT];
  assign w_clr_ovf  = w_wr_ctrl & bus.data_in_i[CTRL_CLR_OVF_BIT];
  assign w_xfer     = r_tvalid & cmd_axis.cmd_axis_tready_i;
  assign w_load     = (~r_tvalid | cmd_axis.cmd_axis_tready_i) & ~w_empty;

  sync_fifo #(
    .WIDTH   (32),
    .DEPTH   (DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n_i),
    .push  (w_wr_data),
    .pop   (w_load),
    .flush (w_flush),
    .wdata (bus.data_in_i),
    .rdata (w_head),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

  // Output register: never retracted by flush, only by acceptance or reset.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_head;
    end else if (w_xfer) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i)                r_ovf <= 1'b0;
    else if (w_wr_data && w_full)  r_ovf <= 1'b1;
    else if (w_clr_ovf)            r_ovf <= 1'b0;
  end

`ifdef GRAPHITE_CMD_TX_STATS_EN
  logic [31:0] r_stats;

  always_ff @(posedge clk) begin
    if (!reset_n_i)      r_stats <= '0;
    else if (w_wr_stats) r_stats <= '0;
    else if (w_xfer)     r_stats <= r_stats + 32'd1;
  end

  assign w_stats = r_stats;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_wr_stats;
  assign w_stats        = '0;
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.addr_i)
      REG_STATUS: w_rdata = pack_status(16'(w_level), w_empty, w_full, r_ovf, r_tvalid);
      REG_STATS:  w_rdata = w_stats;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_ack      <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_ack      <= w_accept;
      r_data_out <= (w_accept && !bus.wr_i) ? w_rdata : '0;
    end
  end

  assign bus.ack_o                  = r_ack;
  assign bus.data_out_o             = r_data_out;
  assign cmd_axis.cmd_axis_tvalid_o = r_tvalid;
  assign cmd_axis.cmd_axis_tdata_o  = r_tdata;
  assign irq_o                      = (w_level <= LEVEL_W'(DEPTH / 2));

endmodule
`default_nettype wire

// File: tb/tb_graphite_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_graphite_cmd_tx
// Purpose  : Scoreboard bench for graphite_cmd_tx with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_graphite_cmd_tx;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;

  graphite_bus_if  bus();
  graphite_axis_if axis();

  graphite_cmd_tx #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n_i (rst_n),
    .bus       (bus),
    .cmd_axis  (axis),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 0;
  bit stop_rand = 0;

  // Reference state: words waiting in the FIFO, output slot occupancy,
  // expected delivery order and expected read data.
  logic [31:0] m_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] rd_exp[$];
  bit          m_vld, m_ov, m_ack;
  logic [31:0] m_cnt;

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[LW-1:0] = LW'(m_q.size());
    s[16] = (m_q.size() == 0);
    s[17] = (m_q.size() == DEPTH);
    s[18] = m_ov;
    s[19] = m_vld;
    return s;
  endfunction

  task automatic model_step();
    bit acc, hs, pre_full, ld;
    logic [31:0] rd;
    if (!rst_n) begin
      m_ack = 0; m_vld = 0; m_ov = 0; m_cnt = '0;
      m_q.delete(); exp_q.delete(); rd_exp.delete();
      return;
    end
    acc      = bus.sel_i && !m_ack;
    hs       = m_vld && axis.cmd_axis_tready_i;
    pre_full = (m_q.size() == DEPTH);
    if (acc && !bus.wr_i) begin
      rd = '0;
      if (bus.addr_i == 2'd1) rd = model_status();
`ifdef GRAPHITE_CMD_TX_STATS_EN
      if (bus.addr_i == 2'd3) rd = m_cnt;
`endif
      rd_exp.push_back(rd);
    end
    ld = (!m_vld || axis.cmd_axis_tready_i) && (m_q.size() > 0);
    if (ld) begin
      void'(m_q.pop_front());
      m_vld = 1;
    end else if (hs) begin
      m_vld = 0;
    end
    if (acc && bus.wr_i && bus.addr_i == 2'd2 && bus.data_in_i[0]) begin
      repeat (m_q.size()) if (exp_q.size() > 0) void'(exp_q.pop_back());
      m_q.delete();
    end
    if (acc && bus.wr_i && bus.addr_i == 2'd0) begin
      if (pre_full) m_ov = 1;
      else begin
        m_q.push_back(bus.data_in_i);
        exp_q.push_back(bus.data_in_i);
      end
    end
    if (acc && bus.wr_i && bus.addr_i == 2'd2 && bus.data_in_i[1]) m_ov = 0;
    if (acc && bus.wr_i && bus.addr_i == 2'd3) m_cnt = '0;
    else if (hs) m_cnt = m_cnt + 32'd1;
    m_ack = acc;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compares DUT outputs against the model half a cycle after each edge.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      n_cmp++;
      if (axis.cmd_axis_tvalid_o !== m_vld) begin
        n_err++;
        $display("FAIL tvalid t=%0t got=%b exp=%b", $time, axis.cmd_axis_tvalid_o, m_vld);
      end
      n_cmp++;
      if (irq !== (m_q.size() <= DEPTH / 2)) begin
        n_err++;
        $display("FAIL irq t=%0t got=%b level=%0d", $time, irq, m_q.size());
      end
      n_cmp++;
      if (bus.ack_o !== m_ack) begin
        n_err++;
        $display("FAIL ack t=%0t got=%b exp=%b", $time, bus.ack_o, m_ack);
      end
      if (bus.ack_o === 1'b1 && rd_exp.size() > 0) begin
        logic [31:0] e;
        e = rd_exp.pop_front();
        n_cmp++;
        if (bus.data_out_o !== e) begin
          n_err++;
          $display("FAIL rdata t=%0t got=%h exp=%h", $time, bus.data_out_o, e);
        end
      end
      if (rst_n && axis.cmd_axis_tvalid_o === 1'b1 && axis.cmd_axis_tready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL tdata t=%0t got=%h exp=<none>", $time, axis.cmd_axis_tdata_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (axis.cmd_axis_tdata_o !== e) begin
            n_err++;
            $display("FAIL tdata t=%0t got=%h exp=%h", $time, axis.cmd_axis_tdata_o, e);
          end
        end
      end
    end
  end

  task automatic bus_acc(input logic w, input logic [1:0] a, input logic [31:0] d,
                         output logic [31:0] rdata);
    bit got;
    got   = 0;
    rdata = '0;
    @(posedge clk); #1;
    bus.sel_i = 1'b1; bus.wr_i = w; bus.addr_i = a; bus.data_in_i = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o === 1'b1) begin
        got   = 1;
        rdata = bus.data_out_o;
      end
    end
    bus.sel_i = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL bus_timeout addr=%0d got=no_ack exp=ack", a);
    end
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    axis.cmd_axis_tready_i = r;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_const(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    bus.sel_i = 0; bus.wr_i = 0; bus.addr_i = '0; bus.data_in_i = '0;
    axis.cmd_axis_tready_i = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1;

    // Reset while a word is pending and tready is low
    bus_acc(1, 2'd0, 32'h1111_2222, rd);
    idle(3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    bus_acc(0, 2'd1, '0, rd);
    check_const("status_after_reset", rd, 32'h0001_0000);

    // Single write with tready high
    set_ready(1);
    bus_acc(1, 2'd0, 32'hDEAD_BEEF, rd);
    idle(4);

    // Backpressure: three words, status, then release
    set_ready(0);
    for (int i = 0; i < 3; i++) bus_acc(1, 2'd0, 32'hA000_0000 + i, rd);
    idle(2);
    bus_acc(0, 2'd1, '0, rd);
    check_const("status_backpressure", rd, 32'h0008_0002);
    set_ready(1);
    idle(6);

    // Overflow: 18 writes into a stalled stream
    set_ready(0);
    for (int i = 0; i < 18; i++) bus_acc(1, 2'd0, 32'hB000_0000 + i, rd);
    bus_acc(0, 2'd1, '0, rd);
    check_const("status_overflow", rd, 32'h000E_0010);
    bus_acc(1, 2'd2, 32'h2, rd);
    bus_acc(0, 2'd1, '0, rd);
    set_ready(1);
    idle(24);

    // Flush with a word parked in the output register
    set_ready(0);
    for (int i = 0; i < 5; i++) bus_acc(1, 2'd0, 32'hC000_0000 + i, rd);
    bus_acc(1, 2'd2, 32'h1, rd);
    bus_acc(0, 2'd1, '0, rd);
    check_const("status_flush", rd, 32'h0009_0000);
    set_ready(1);
    idle(6);

    // Accepted-word counter
    bus_acc(1, 2'd3, 32'h5A5A_5A5A, rd);
    for (int i = 0; i < 100; i++) bus_acc(1, 2'd0, $urandom, rd);
    idle(6);
    bus_acc(0, 2'd3, '0, rd);
`ifdef GRAPHITE_CMD_TX_STATS_EN
    check_const("stats_count", rd, 32'd100);
`else
    check_const("stats_count", rd, 32'd0);
`endif
    bus_acc(1, 2'd3, '0, rd);
    bus_acc(0, 2'd3, '0, rd);
    check_const("stats_cleared", rd, 32'd0);

    // Randomized mix of accesses against a randomly throttled stream
    fork
      begin
        for (int t = 0; t < 500; t++) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 70)      bus_acc(1, 2'd0, $urandom, rd);
          else if (r < 78) bus_acc(0, 2'd1, '0, rd);
          else if (r < 82) bus_acc(0, 2'd0, '0, rd);
          else if (r < 86) bus_acc(1, 2'd2, 32'($urandom_range(0, 3)), rd);
          else if (r < 89) bus_acc(0, 2'd2, '0, rd);
          else if (r < 95) bus_acc(0, 2'd3, '0, rd);
          else             bus_acc(1, 2'd3, $urandom, rd);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        stop_rand = 1;
      end
      begin
        int bias;
        bias = 50;
        for (int c = 0; !stop_rand; c++) begin
          if (c % 100 == 0) bias = (c / 100) % 4 == 0 ? 0 : ((c / 100) % 4 == 1 ? 30 : 95);
          @(posedge clk); #1;
          axis.cmd_axis_tready_i = ($urandom_range(0, 99) < bias);
        end
      end
    join

    set_ready(1);
    idle(40);
    check_const("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
